// File: rtl/alarm_scheduler.sv
// alarm_scheduler: multi-slot alarm comparator with shared-buzzer arbitration,
// snooze, dismiss and ring timeout sequencing.
module alarm_scheduler #(
   parameter int NUM_ALARMS  = 4,
   parameter int RING_SECS   = 30,
   parameter int SNOOZE_SECS = 300,
   parameter int MAX_SNOOZE  = 3,
   parameter int IDXW        = (NUM_ALARMS > 2) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic [4:0]            hours,
   input  logic [5:0]            mins,
   input  logic [5:0]            secs,
   input  logic                  cfg_we,
   input  logic [IDXW-1:0]       cfg_idx,
   input  logic                  cfg_en,
   input  logic [4:0]            cfg_hours,
   input  logic [5:0]            cfg_mins,
   input  logic [5:0]            cfg_secs,
   input  logic                  snooze,
   input  logic                  dismiss,
   output logic                  buzzer,
   output logic                  busy,
   output logic [IDXW-1:0]       active_idx,
   output logic [NUM_ALARMS-1:0] missed
);
   localparam int RW = $clog2(RING_SECS + 1);
   localparam int SW = $clog2(SNOOZE_SECS + 1);
   localparam int CW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
   localparam logic [NUM_ALARMS-1:0] ONE = 1;
   localparam logic [NUM_ALARMS-1:0] NONE = '0;

   typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

   state_t                state, state_n;
   logic [NUM_ALARMS-1:0] en, match, pending, pend, pend_n, mis_n, wr_m, act_m;
   logic [4:0]            s_h [NUM_ALARMS];
   logic [5:0]            s_m [NUM_ALARMS];
   logic [5:0]            s_s [NUM_ALARMS];
   logic [RW-1:0]         ring_cnt, ring_n;
   logic [SW-1:0]         snz_timer, snz_n;
   logic [CW-1:0]         snooze_cnt, scnt_n;
   logic [IDXW-1:0]       idx_n;
   logic                  wr, kill, fin, timeout;

   function automatic logic [IDXW-1:0] first(input logic [NUM_ALARMS-1:0] v);
      first = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) if (v[i]) first = IDXW'(i);
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_ALARMS; i++)
         match[i] = tick && en[i] && s_h[i] == hours && s_m[i] == mins && s_s[i] == secs;
   end

   assign busy = state != IDLE;

   always_comb begin
      wr = cfg_we && ({1'b0, cfg_idx} < (IDXW + 1)'(NUM_ALARMS));
      wr_m = wr ? ONE << cfg_idx : NONE;
      act_m = ONE << active_idx;
      kill = wr && !cfg_en && cfg_idx == active_idx;
      // the slot that takes the buzzer never lands in pending
      pend = (pending | (match & ~((state == IDLE) ? ONE << first(match) : act_m))) & ~wr_m;
      state_n = state;
      idx_n = active_idx;
      ring_n = ring_cnt;
      snz_n = snz_timer;
      scnt_n = snooze_cnt;
      fin = 1'b0;
      timeout = 1'b0;
      case (state)
         IDLE: if (|match) begin
            state_n = RINGING;
            idx_n = first(match);
            ring_n = '0;
            snz_n = '0;
            scnt_n = '0;
         end
         RINGING: if (dismiss || kill) fin = 1'b1;
         else if (snooze && snooze_cnt < CW'(MAX_SNOOZE)) begin
            state_n = SNOOZE;
            snz_n = SW'(SNOOZE_SECS);
            scnt_n = snooze_cnt + CW'(1);
         end else if (tick) begin
            timeout = ring_cnt == RW'(RING_SECS - 1);
            fin = timeout;
            ring_n = timeout ? ring_cnt : ring_cnt + RW'(1);
         end
         SNOOZE: if (dismiss || kill) fin = 1'b1;
         else if (tick) begin
            state_n = (snz_timer == SW'(1)) ? RINGING : SNOOZE;
            ring_n = (snz_timer == SW'(1)) ? '0 : ring_cnt;
            snz_n = snz_timer - SW'(1);
         end
         default: state_n = IDLE;
      endcase
      mis_n = (missed | (timeout ? act_m : NONE)) & ~wr_m;
      pend_n = pend;
      if (fin) begin
         ring_n = '0;
         snz_n = '0;
         scnt_n = '0;
         state_n = |pend ? RINGING : IDLE;
         idx_n = |pend ? first(pend) : active_idx;
         pend_n = pend & ~(|pend ? ONE << first(pend) : NONE);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         buzzer <= 1'b0;
         active_idx <= '0;
         missed <= '0;
         pending <= '0;
         ring_cnt <= '0;
         snz_timer <= '0;
         snooze_cnt <= '0;
         en <= '0;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            s_h[i] <= '0;
            s_m[i] <= '0;
            s_s[i] <= '0;
         end
      end else begin
         state <= state_n;
         buzzer <= state_n == RINGING;
         active_idx <= idx_n;
         missed <= mis_n;
         pending <= pend_n;
         ring_cnt <= ring_n;
         snz_timer <= snz_n;
         snooze_cnt <= scnt_n;
         if (wr) begin
            en[cfg_idx] <= cfg_en;
            s_h[cfg_idx] <= cfg_hours;
            s_m[cfg_idx] <= cfg_mins;
            s_s[cfg_idx] <= cfg_secs;
         end
      end
   end
endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

Multi-slot alarm controller for the timekeeping datapath. It holds NUM_ALARMS programmable alarm times and compares them against the running hours/mins/secs once per second tick. It arbitrates the single shared buzzer between slots that fire together or overlap, and sequences ring, snooze, dismiss and timeout.

## Interface
- NUM_ALARMS, 4: number of alarm slots (2..16); IDXW = max(1, clog2(NUM_ALARMS)).
- RING_SECS, 30: ticks the buzzer rings before auto-timeout (≥1).
- SNOOZE_SECS, 300: ticks spent in snooze before re-ringing (≥1).
- MAX_SNOOZE, 3: snoozes allowed per alarm event.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle pulse per elapsed second; time inputs are valid in the tick cycle
- hours  in  5  current hours
- mins  in  6  current minutes
- secs  in  6  current seconds
- cfg_we  in  1  write slot cfg_idx
- cfg_idx  in  IDXW  slot index (out-of-range writes ignored)
- cfg_en  in  1  slot enable
- cfg_hours / cfg_mins / cfg_secs  in  5/6/6  slot alarm time
- snooze  in  1  single-cycle snooze request
- dismiss  in  1  single-cycle dismiss request
- buzzer  out  1  registered buzzer drive
- busy  out  1  state ≠ IDLE
- active_idx  out  IDXW  slot currently ringing/snoozed
- missed  out  NUM_ALARMS  sticky per-slot timed-out flags

## Operation
- Slot storage: en, hours, mins, secs per slot. Reset value: all zero/disabled.
- Match: in a tick cycle, slot i matches when en[i] and all three fields equal the time inputs. The match uses pre-write slot contents if cfg_we hits the same slot in that cycle.
- FSM states: IDLE, RINGING, SNOOZE.
- IDLE: any match → RINGING with active_idx = lowest matching index. Other matches set their pending bits.
- RINGING/SNOOZE: new matches set pending bits. A match on active_idx itself is ignored.
- RINGING: ring_cnt increments on each tick.
  - On a tick where ring_cnt == RING_SECS-1, the alarm times out: set missed[active_idx] and finish.
  - snooze with snooze_cnt < MAX_SNOOZE → SNOOZE. Load snz_timer = SNOOZE_SECS, increment snooze_cnt. Otherwise snooze is ignored.
- SNOOZE: snz_timer decrements per tick. On a tick with snz_timer == 1 → RINGING with ring_cnt = 0.
- dismiss in RINGING or SNOOZE finishes the event. dismiss wins over snooze in the same cycle, and over timeout in the same cycle (missed is not set).
- Writing the active slot with cfg_en=0 while busy finishes the event.
- Any cfg write clears that slot's pending and missed bits.
- Finish: if pending ≠ 0, go to RINGING with the lowest pending index, clear its pending bit, and zero ring_cnt and snooze_cnt. Otherwise go to IDLE.
- Widths: ring_cnt and snz_timer are sized from their parameters; snooze_cnt is sized from MAX_SNOOZE. None of them wrap; all are cleared on entering RINGING from IDLE or a finish.

## Timing
- Reset (async, any state): state IDLE, buzzer 0, busy 0, active_idx 0, missed 0, pending 0, all counters 0, slots disabled.
- buzzer is registered as (next_state == RINGING). Match in tick cycle T gives buzzer=1 and busy=1 from the edge ending T.
- Undisturbed ring: buzzer high for exactly RING_SECS ticks. It drops on the edge of the RING_SECS-th tick cycle.
- snooze or dismiss in cycle T: buzzer 0 from the edge ending T.
- Chained pending alarm: buzzer stays 1 continuously across the finish, and active_idx changes on the same edge.
- Config writes take effect on the edge ending the cfg_we cycle.
- snooze or dismiss in IDLE is ignored; no state changes.

## Test plan
- Slot 1 = 07:30:00 enabled; tick with time 07:30:00 → buzzer=1, active_idx=1 next cycle. With no inputs for 30 ticks, buzzer drops and missed=4'b0010.
- Slots 0 and 2 both 06:00:00; match, then dismiss → slot 0 rings first. After dismiss, slot 2 rings with no buzzer gap, then dismiss → IDLE, missed=0.
- SNOOZE_SECS=5: ring, then snooze → buzzer 0 for 5 ticks, then re-rings. The 4th snooze request is ignored; buzzer stays 1.
- snooze and dismiss in the same cycle → IDLE, buzzer 0, snooze_cnt unused.
- While slot 0 rings, write slot 0 with cfg_en=0 → buzzer 0 next cycle, IDLE. Write slot 3 during its own match tick → match uses the old contents.
- Assert reset mid-SNOOZE → all outputs 0 immediately (async). A later matching tick does not ring because slots are disabled.
